mem_write_buffer: RTL and testbench
===================================

// Module: mem_write_buffer
// PURPOSE
//  Store queue sitting directly upstream of the data memory on the single shared RAM port.
//  Accepts CPU stores into a FIFO and drains them to memory one word per cycle whenever no load owns the port.
//  Loads get read-after-write correctness by forwarding from the youngest matching buffered store.
//  Drives the memory's A/WD/we inputs and merges its RD output into the CPU load result.
// PARAMETERS
//  AW     32  address width (word address presented to memory A)
//  DW     32  data word width
//  DEPTH  4   FIFO entries; power of 2, >=2
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous active-low reset
//  st_valid  in   1       CPU store request
//  st_addr   in   AW      store address
//  st_data   in   DW      store data
//  st_ready  out  1       buffer can accept a store (= ~full)
//  ld_req    in   1       CPU load owns the memory port this cycle
//  ld_addr   in   AW      load address
//  ld_data   out  DW      load result (forwarded or mem_rd)
//  ld_fwd    out  1       ld_data came from the buffer
//  mem_a     out  AW      to memory A
//  mem_wd    out  DW      to memory WD
//  mem_we    out  1       to memory we
//  mem_rd    in   DW      from memory RD (combinational read)
//  count     out  log2(DEPTH)+1  occupied entries
//  empty     out  1       count==0; used by halt/flush logic
// BEHAVIOUR
//  Reset (rst==0 at posedge): rd_ptr=wr_ptr=0, count=0, valid bits cleared.
//  Reset values: empty=1, st_ready=1, mem_we=0, ld_fwd=0, count=0.
//  Reset mid-operation discards all pending stores; no drain occurs that cycle.
//  Storage: circular FIFO of {addr,data}; pointers wrap modulo DEPTH.
//  Push: st_valid & st_ready at posedge writes the tail entry; wr_ptr++, count++.
//  st_ready = ~full, purely from registered count. No push into a slot freed that same cycle.
//  Port arbitration (combinational from state + ld_req):
//   - ld_req=1: mem_a=ld_addr, mem_we=0. Drain stalls; loads always win.
//   - ld_req=0 & ~empty: mem_a=head.addr, mem_wd=head.data, mem_we=1. Pop at the same posedge memory writes; rd_ptr++, count--.
//   - ld_req=0 & empty: mem_we=0, mem_a=head.addr (don't-care).
//  Simultaneous push+pop: count unchanged; both pointers advance.
//  Forwarding: ld_fwd=1 iff any valid entry has addr==ld_addr.
//   - ld_data = data of the youngest such entry (nearest to wr_ptr-1), else mem_rd.
//   - A store pushed in the same cycle is not visible until the next cycle.
//   - The head entry popping this cycle still forwards this cycle.
//  Store drain order is strict FIFO. Latency store->memory = 1 + number of entries ahead + ld_req stall cycles.
//  Full (count==DEPTH): st_ready=0, incoming st_valid ignored; CPU must hold the request.
//  Empty with ld_req=0: port idle.
//  Address compare is full AW bits; no byte lanes; mem_wd always a full word.
// CONFIGURATION
//  WBUF_COALESCE_EN defined:
//   - A push whose st_addr equals the youngest valid entry's addr overwrites that entry's data in place.
//   - No pointer/count change; accepted even when full.
//   - Exception: if that entry is the head being popped this cycle, a normal push is performed instead.
//  WBUF_COALESCE_EN undefined: every accepted store allocates a new entry; duplicates drain in order.
// TESTING
//  Store 0x5->A=3, ld_req=0 -> next cycle mem_we=1, mem_a=3, mem_wd=5; then empty=1.
//  Hold ld_req=1; push 4 stores (A=1..4) -> count=4, st_ready=0, mem_we=0; 5th held.
//   Drop ld_req -> 4 drains in order A=1,2,3,4 on consecutive cycles.
//  Push A=7 D=0x11, then A=7 D=0x22, ld_req=1, ld_addr=7 -> ld_fwd=1, ld_data=0x22.
//   ld_addr=8 -> ld_fwd=0, ld_data=mem_rd.
//  Full buffer, ld_req=0, st_valid=1 -> no push that cycle (st_ready=0); pop A=head; push accepted next cycle.
//  Two entries pending, rst=0 one cycle -> count=0, empty=1, mem_we=0; memory contents unchanged afterwards.
//  WBUF_COALESCE_EN: push A=9 D=1 then A=9 D=2 while ld_req=1 -> count=1; after drain mem word 9 =2 via a single write.

Source files
------------

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: store FIFO in front of the single shared data-memory port.
// Stores drain one word per cycle when no load owns the port; loads win arbitration
// and get read-after-write data forwarded from the youngest matching buffered store.
// Optional feature macro: WBUF_COALESCE_EN (merge a store into the youngest entry
// when the addresses match, instead of allocating a new entry).
module mem_write_buffer #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_req,
    input  logic [AW-1:0]              ld_addr,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_fwd,
    output logic [AW-1:0]              mem_a,
    output logic [DW-1:0]              mem_wd,
    output logic                       mem_we,
    input  logic [DW-1:0]              mem_rd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Entry storage and bookkeeping
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic          full_c;
    logic          empty_c;
    logic          pop_c;
    logic          push_c;
    logic          coal_c;
    logic [PW-1:0] young_c;
    logic          fwd_hit_c;
    logic [DW-1:0] fwd_data_c;

    // Occupancy flags come only from the registered count
    always_comb begin
        full_c   = (count_q == CW'(DEPTH));
        empty_c  = (count_q == '0);
        young_c  = wr_ptr_q - PW'(1);
    end

    // Port arbitration: a load always owns the port; otherwise drain the head entry.
    // A cycle held in reset never writes memory.
    always_comb begin
        pop_c  = rst & ~ld_req & ~empty_c;
        mem_we = pop_c;
        mem_a  = ld_req ? ld_addr : addr_q[rd_ptr_q];
        mem_wd = data_q[rd_ptr_q];
    end

    // Store acceptance, with optional in-place merge into the youngest entry
    always_comb begin
        coal_c = 1'b0;
`ifdef WBUF_COALESCE_EN
        // Merging into an entry that is leaving this cycle would lose the data,
        // so a lone head being popped takes a normal push instead.
        coal_c = st_valid & ~empty_c & (addr_q[young_c] == st_addr)
               & ~(pop_c & (count_q == CW'(1)));
`endif
        push_c = st_valid & ~full_c & ~coal_c;
    end

    // Next-state for pointers, count and valid bits
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (pop_c) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_c) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage; contents are meaningless unless the matching valid bit is set
    always_ff @(posedge clk) begin
        if (rst && push_c) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
        if (rst && coal_c) begin
            data_q[young_c] <= st_data;
        end
    end

    // Forwarding: scan oldest to youngest so the last match is the youngest store
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[rd_ptr_q + PW'(i)] && (addr_q[rd_ptr_q + PW'(i)] == ld_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    // Output assembly
    always_comb begin
        ld_fwd   = fwd_hit_c;
        ld_data  = fwd_hit_c ? fwd_data_c : mem_rd;
        st_ready = ~full_c;
        empty    = empty_c;
        count    = count_q;
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: randomized + directed bench against a queue-based model
// of the store buffer and an independent reference copy of memory.
module tb_mem_write_buffer;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;
    logic [2:0]    count;
    logic          empty;

    mem_write_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_fwd(ld_fwd),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Memory actually written by the DUT (16 words, small address space)
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    assign mem_rd = mem[mem_a[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[3:0]] <= mem_wd;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs held over that edge
    task automatic model_step();
        int  sz;
        bit  pop;
        sz = q.size();
        if (!rst) begin
            q.delete();
            return;
        end
        pop = !ld_req && sz > 0;
        if (pop) begin
            ref_mem[q[0].a[3:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (st_valid) begin
`ifdef WBUF_COALESCE_EN
            if (sz > 0 && !(pop && sz == 1) && q[q.size()-1].a == st_addr) begin
                q[q.size()-1].d = st_data;
            end else if (sz < DEPTH) begin
                q.push_back('{st_addr, st_data});
            end
`else
            if (sz < DEPTH) q.push_back('{st_addr, st_data});
`endif
        end
    endtask

    // Compare every observable output against the model for the current inputs
    task automatic model_check();
        bit            hit;
        logic [DW-1:0] fd;
        bit            we;
        hit = 0;
        fd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].a == ld_addr) begin
                hit = 1;
                fd  = q[i].d;
            end
        end
        we = rst && !ld_req && q.size() > 0;
        chk("count",    64'(count),    64'(q.size()));
        chk("empty",    64'(empty),    64'(q.size() == 0));
        chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
        chk("mem_we",   64'(mem_we),   64'(we));
        chk("ld_fwd",   64'(ld_fwd),   64'(hit));
        if (we) begin
            chk("drain_a",  64'(mem_a),  64'(q[0].a));
            chk("drain_wd", 64'(mem_wd), 64'(q[0].d));
        end
        if (ld_req) begin
            chk("load_a",  64'(mem_a),   64'(ld_addr));
            chk("ld_data", 64'(ld_data), 64'(hit ? fd : ref_mem[ld_addr[3:0]]));
        end
    endtask

    task automatic set(input logic r, input logic sv, input logic [AW-1:0] sa,
                       input logic [DW-1:0] sd, input logic lr, input logic [AW-1:0] la);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = r; st_valid = sv; st_addr = sa; st_data = sd; ld_req = lr; ld_addr = la;
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) set(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            mem[k]     = 32'hA000_0000 | 32'(k);
            ref_mem[k] = 32'hA000_0000 | 32'(k);
        end
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_req = 1'b0; ld_addr = '0;

        // Reset state
        set(1'b0, 1'b0, '0, '0, 1'b0, '0);
        set(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(st_ready), 64'd1);
        chk("rst_we",    64'(mem_we), 64'd0);
        chk("rst_fwd",   64'(ld_fwd), 64'd0);

        // Single store drains on the next cycle
        set(1'b1, 1'b1, 32'd3, 32'h5, 1'b0, '0);
        set(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("st1_we", 64'(mem_we), 64'd1);
        chk("st1_a",  64'(mem_a),  64'd3);
        chk("st1_wd", 64'(mem_wd), 64'h5);
        set(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("st1_empty", 64'(empty), 64'd1);

        // Fill while loads hold the port, then drain in order
        for (int k = 1; k <= 4; k++) set(1'b1, 1'b1, 32'(k), 32'h100 + 32'(k), 1'b1, 32'd0);
        set(1'b1, 1'b1, 32'd5, 32'h55, 1'b1, 32'd0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(st_ready), 64'd0);
        chk("full_we",    64'(mem_we), 64'd0);
        set(1'b1, 1'b1, 32'd5, 32'h55, 1'b0, 32'd0);
        chk("drain1_a", 64'(mem_a), 64'd1);
        chk("drain1_count", 64'(count), 64'd4);
        set(1'b1, 1'b1, 32'd5, 32'h55, 1'b0, 32'd0);
        chk("drain2_a", 64'(mem_a), 64'd2);
        chk("drain2_count", 64'(count), 64'd3);
        set(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("drain3_a", 64'(mem_a), 64'd3);
        chk("push_after_full", 64'(count), 64'd3);
        idle(4);
        chk("mem1", 64'(mem[1]), 64'h101);
        chk("mem4", 64'(mem[4]), 64'h104);
        chk("mem5", 64'(mem[5]), 64'h55);

        // Forwarding from the youngest matching store
        set(1'b1, 1'b1, 32'd7, 32'h11, 1'b1, 32'd7);
        set(1'b1, 1'b1, 32'd7, 32'h22, 1'b1, 32'd7);
        chk("fwd_old_fwd",  64'(ld_fwd),  64'd1);
        chk("fwd_old_data", 64'(ld_data), 64'h11);
        set(1'b1, 1'b0, '0, '0, 1'b1, 32'd7);
        chk("fwd_fwd",  64'(ld_fwd),  64'd1);
        chk("fwd_data", 64'(ld_data), 64'h22);
        set(1'b1, 1'b0, '0, '0, 1'b1, 32'd8);
        chk("nofwd_fwd",  64'(ld_fwd),  64'd0);
        chk("nofwd_data", 64'(ld_data), 64'hA000_0008);
        idle(4);
        chk("mem7", 64'(mem[7]), 64'h22);

        // Reset with stores pending discards them without writing memory
        set(1'b1, 1'b1, 32'd10, 32'hDEAD, 1'b1, 32'd0);
        set(1'b1, 1'b1, 32'd11, 32'hBEEF, 1'b1, 32'd0);
        set(1'b0, 1'b0, '0, '0, 1'b0, '0);
        chk("rstmid_we", 64'(mem_we), 64'd0);
        set(1'b1, 1'b0, '0, '0, 1'b0, '0);
        chk("rstmid_count", 64'(count), 64'd0);
        chk("rstmid_empty", 64'(empty), 64'd1);
        idle(3);
        chk("rstmid_mem10", 64'(mem[10]), 64'hA000_000A);
        chk("rstmid_mem11", 64'(mem[11]), 64'hA000_000B);

`ifdef WBUF_COALESCE_EN
        set(1'b1, 1'b1, 32'd9, 32'd1, 1'b1, 32'd0);
        set(1'b1, 1'b1, 32'd9, 32'd2, 1'b1, 32'd0);
        set(1'b1, 1'b0, '0, '0, 1'b1, 32'd0);
        chk("coal_count", 64'(count), 64'd1);
        idle(3);
        chk("coal_mem9", 64'(mem[9]), 64'd2);
`endif

        // Randomized traffic with phases of varying load pressure
        for (int c = 0; c < 4000; c++) begin
            int unsigned lp;
            int unsigned am;
            lp = ((c / 250) % 4 == 0) ? 10 : ((c / 250) % 4 == 1) ? 50 :
                 ((c / 250) % 4 == 2) ? 90 : 0;
            am = ((c / 500) % 2 == 0) ? 3 : 15;
            set(($urandom_range(0, 127) != 0),
                ($urandom_range(0, 99) < 60),
                32'($urandom_range(0, am)),
                32'($urandom),
                ($urandom_range(0, 99) < lp),
                32'($urandom_range(0, am)));
        end
        idle(DEPTH + 2);
        for (int k = 0; k < 16; k++) chk("final_mem", 64'(mem[k]), 64'(ref_mem[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
